// File: rtl/sysid_ext_if.sv
// Purpose : Avalon-MM slave bus bundle for the sysid_ext peripheral
//           (word address, read/write strobes, write data, registered read data).
// Ports   : master drives address/read/write/writedata; slave drives readdata/readdatavalid.
interface sysid_ext_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_ext.sv
// Purpose : System ID / build timestamp / uptime-counter peripheral on an Avalon-MM bus,
//           with a scratch register, CTRL/STATUS and an optional SECONDS counter.
// Latency : read sampled at edge N returns readdata with a readdatavalid pulse at edge N+1.
// Backpr. : none; the slave accepts a read or write every cycle.
// Ports   : clock, reset (async, active-high), bus (sysid_ext_if.slave).
// Option  : define SYSID_SECONDS_EN to build the prescaler and SECONDS register.
module sysid_ext #(
    parameter logic [31:0]          SYSTEM_ID   = 32'h0000_0000,
    parameter logic [31:0]          TIMESTAMP   = 32'h4F2B_2AD0,
    parameter int                   COUNTER_W   = 64,
    parameter logic [COUNTER_W-1:0] COUNTER_RST = '0,
    parameter logic [31:0]          SCRATCH_RST = 32'h0000_0000,
    parameter int                   CLK_FREQ_HZ = 50000000
) (
    input  logic      clock,
    input  logic      reset,
    sysid_ext_if.slave bus
);

    logic [COUNTER_W-1:0] counter;
    logic [31:0]          shadow;
    logic [31:0]          scratch;
    logic                 wrap_sticky;
    logic [31:0]          seconds_rd;
    logic                 has_seconds;
    logic [31:0]          rd_mux;
    logic [31:0]          cnt_hi_ext;

    logic wr_ctrl;
    logic clr_cnt;
    logic clr_sticky;
    logic wr_scratch;
    logic rd_lo;
    logic at_max;

    assign wr_ctrl    = bus.write && (bus.address == 3'd5);
    assign clr_cnt    = wr_ctrl && bus.writedata[0];
    assign clr_sticky = wr_ctrl && bus.writedata[1];
    assign wr_scratch = bus.write && (bus.address == 3'd4);
    assign rd_lo      = bus.read && (bus.address == 3'd2);
    assign at_max     = &counter;

    // Upper counter bits, zero-extended to a full word for the shadow.
    assign cnt_hi_ext = 32'(counter[COUNTER_W-1:32]);

`ifdef SYSID_SECONDS_EN
    localparam logic [31:0] PRESC_TC = 32'(CLK_FREQ_HZ - 1);

    logic [31:0] prescaler;
    logic [31:0] seconds;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            seconds   <= '0;
        end else if (clr_cnt) begin
            prescaler <= '0;
            seconds   <= '0;
        end else if (prescaler == PRESC_TC) begin
            prescaler <= '0;
            // Wraps naturally; deliberately independent of wrap_sticky.
            seconds   <= seconds + 32'd1;
        end else begin
            prescaler <= prescaler + 32'd1;
        end
    end

    assign seconds_rd  = seconds;
    assign has_seconds = 1'b1;
`else
    localparam int unused_clk_freq = CLK_FREQ_HZ;

    assign seconds_rd  = '0;
    assign has_seconds = 1'b0;
`endif

    // Read mux sees pre-edge state, so a same-cycle write is not visible yet.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            3'd0:    rd_mux = SYSTEM_ID;
            3'd1:    rd_mux = TIMESTAMP;
            3'd2:    rd_mux = counter[31:0];
            3'd3:    rd_mux = shadow;
            3'd4:    rd_mux = scratch;
            3'd5:    rd_mux = {29'd0, has_seconds, wrap_sticky, 1'b0};
            3'd6:    rd_mux = seconds_rd;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter           <= COUNTER_RST;
            shadow            <= '0;
            scratch           <= SCRATCH_RST;
            wrap_sticky       <= 1'b0;
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            // Clear beats increment; all-ones + 1 wraps to 0 on its own.
            if (clr_cnt) begin
                counter <= COUNTER_RST;
            end else begin
                counter <= counter + COUNTER_W'(1);
            end

            // Wrap beats sticky-clear, but a counter clear suppresses the wrap.
            if (at_max && !clr_cnt) begin
                wrap_sticky <= 1'b1;
            end else if (clr_sticky) begin
                wrap_sticky <= 1'b0;
            end

            // Capture the high half with the low half so a later HI read is coherent.
            if (rd_lo) begin
                shadow <= cnt_hi_ext;
            end

            if (wr_scratch) begin
                scratch <= bus.writedata;
            end

            bus.readdatavalid <= bus.read;
            if (bus.read) begin
                bus.readdata <= rd_mux;
            end
        end
    end

endmodule
